fsub_f_seq: RTL and testbench

- Multi-cycle IEEE-754 single-precision subtractor for the ISS FP path: computes in1 - in2. It is the subtraction counterpart of the single-cycle FP adder.
- Uses a valid/ready request and response handshake. Alignment and normalization shift one bit per cycle, trading latency for area.
- Sits between the FP issue stage and FP writeback. Rounding is truncation (round toward zero) and the inexact flag is reported.

---
 rtl/fsub_f_seq.sv | 198 +++++++++++++++++++
 tb/tb_fsub_f_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsub_f_seq.sv
// fsub_f_seq: FP32 in1 - in2, truncating, flush-to-zero; ALIGN/NORM shift one bit per cycle.
// Latency: 1 cycle for specials, otherwise ALIGN + ADD + NORM cycles; result is held in DONE until resp_ready.
module fsub_f_seq #(
   parameter int GRS_BITS  = 3,
   parameter int SHIFT_CAP = 27
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_in1,
   input  logic [31:0] req_in2,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_out,
   output logic        resp_inexact,
   output logic        busy
);
   localparam int MW = 24 + GRS_BITS;

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
   typedef logic [MW:0] mag_t;

   state_t        state_q, state_d;
   logic          sa_q, sa_d, sb_q, sb_d;
   logic [7:0]    exp_q, exp_d, cnt_q, cnt_d;
   logic [MW-1:0] ma_q, ma_d, mb_q, mb_d;
   logic [MW:0]   mag_q, mag_d;
   logic          rsgn_q, rsgn_d;
   logic [31:0]   res_q, res_d;
   logic          inx_q, inx_d;

   // Subtrahend sign is inverted on capture so the datapath only ever adds.
   logic        s1, s2;
   logic [7:0]  e1, e2;
   logic [22:0] f1, f2;
   logic        nan1, nan2, inf1, inf2, zero1, zero2;

   assign s1    = req_in1[31];
   assign s2    = ~req_in2[31];
   assign e1    = req_in1[30:23];
   assign e2    = req_in2[30:23];
   assign f1    = req_in1[22:0];
   assign f2    = req_in2[22:0];
   assign nan1  = (e1 == 8'hFF) && (f1 != 23'd0);
   assign nan2  = (e2 == 8'hFF) && (f2 != 23'd0);
   assign inf1  = (e1 == 8'hFF) && (f1 == 23'd0);
   assign inf2  = (e2 == 8'hFF) && (f2 == 23'd0);
   assign zero1 = (e1 == 8'd0);
   assign zero2 = (e2 == 8'd0);

   logic [MW+1:0] op_a, op_b, sum;
   logic [MW:0]   sum_abs;

   assign op_a    = sa_q ? -{2'b00, ma_q} : {2'b00, ma_q};
   assign op_b    = sb_q ? -{2'b00, mb_q} : {2'b00, mb_q};
   assign sum     = op_a + op_b;
   assign sum_abs = sum[MW+1] ? mag_t'(-sum) : sum[MW:0];

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      exp_d   = exp_q;
      cnt_d   = cnt_q;
      ma_d    = ma_q;
      mb_d    = mb_q;
      mag_d   = mag_q;
      rsgn_d  = rsgn_q;
      res_d   = res_q;
      inx_d   = inx_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               inx_d   = 1'b0;
               state_d = DONE;
               if (nan1 || nan2) begin
                  res_d = 32'h7FC0_0000;
               end else if (inf1 && inf2) begin
                  res_d = (s1 != s2) ? 32'h7FC0_0000 : {s1, 8'hFF, 23'd0};
               end else if (inf1) begin
                  res_d = {s1, 8'hFF, 23'd0};
               end else if (inf2) begin
                  res_d = {s2, 8'hFF, 23'd0};
               end else if (zero1 && zero2) begin
                  res_d = 32'h0000_0000;
               end else if (zero1) begin
                  res_d = {s2, req_in2[30:0]};
               end else if (zero2) begin
                  res_d = {s1, req_in1[30:0]};
               end else begin
                  state_d = ALIGN;
                  if (e2 > e1) begin
                     sa_d  = s2;
                     exp_d = e2;
                     ma_d  = {1'b1, f2, {GRS_BITS{1'b0}}};
                     sb_d  = s1;
                     mb_d  = {1'b1, f1, {GRS_BITS{1'b0}}};
                     cnt_d = e2 - e1;
                  end else begin
                     sa_d  = s1;
                     exp_d = e1;
                     ma_d  = {1'b1, f1, {GRS_BITS{1'b0}}};
                     sb_d  = s2;
                     mb_d  = {1'b1, f2, {GRS_BITS{1'b0}}};
                     cnt_d = e1 - e2;
                  end
               end
            end
         end
         ALIGN: begin
            if (cnt_q >= 8'(SHIFT_CAP)) begin
               mb_d    = {{(MW-1){1'b0}}, |mb_q};
               cnt_d   = 8'd0;
               state_d = ADD;
            end else if (cnt_q == 8'd0) begin
               state_d = ADD;
            end else begin
               mb_d  = {1'b0, mb_q[MW-1:2], mb_q[1] | mb_q[0]};
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1) state_d = ADD;
            end
         end
         ADD: begin
            rsgn_d  = sum[MW+1];
            mag_d   = sum_abs;
            state_d = NORM;
         end
         NORM: begin
            if (mag_q == '0) begin
               res_d   = 32'h0000_0000;
               inx_d   = 1'b0;
               state_d = DONE;
            end else if (mag_q[MW]) begin
               if (exp_q == 8'd254) begin
                  res_d   = {rsgn_q, 8'hFF, 23'd0};
                  inx_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  mag_d = {1'b0, mag_q[MW:2], mag_q[1] | mag_q[0]};
                  exp_d = exp_q + 8'd1;
               end
            end else if (!mag_q[MW-1]) begin
               if (exp_q == 8'd1) begin
                  res_d   = {rsgn_q, 31'd0};
                  inx_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  mag_d = {mag_q[MW-1:0], 1'b0};
                  exp_d = exp_q - 8'd1;
               end
            end else begin
               res_d   = {rsgn_q, exp_q, mag_q[MW-2:GRS_BITS]};
               inx_d   = |mag_q[GRS_BITS-1:0];
               state_d = DONE;
            end
         end
         DONE: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         exp_q   <= 8'd0;
         cnt_q   <= 8'd0;
         ma_q    <= '0;
         mb_q    <= '0;
         mag_q   <= '0;
         rsgn_q  <= 1'b0;
         res_q   <= 32'd0;
         inx_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         exp_q   <= exp_d;
         cnt_q   <= cnt_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         mag_q   <= mag_d;
         rsgn_q  <= rsgn_d;
         res_q   <= res_d;
         inx_q   <= inx_d;
      end
   end

   assign req_ready    = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign resp_valid   = (state_q == DONE);
   assign resp_out     = res_q;
   assign resp_inexact = inx_q;
endmodule

// File: tb/tb_fsub_f_seq.sv
// Bench for fsub_f_seq: directed vector table, handshake corner sequences and random operands
// checked against an exact wide-integer model of truncated FP32 subtraction.
module tb_fsub_f_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_in1 = 32'd0;
   logic [31:0] req_in2 = 32'd0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_out;
   logic        resp_inexact;
   logic        busy;

   int nvec  = 0;
   int nfail = 0;
   bit rdy_leak;

   always #5 clk = ~clk;

   fsub_f_seq dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_in1(req_in1), .req_in2(req_in2),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_out(resp_out), .resp_inexact(resp_inexact),
      .busy(busy)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        x;
      int          lat;
   } vec_t;

   vec_t tbl[$];

   task automatic add_vec(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic x, input int lat);
      vec_t v;
      v.a = a; v.b = b; v.r = r; v.x = x; v.lat = lat;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   // Exact value of each operand in units of 2^-149, then truncate to FP32.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic x);
      logic [299:0] va, vb, m, mask, tmp;
      logic         sa, sb, neg;
      int           p, e;
      sa = a[31];
      sb = ~b[31];
      va = 300'({1'b1, a[22:0]}) << (int'(a[30:23]) - 1);
      vb = 300'({1'b1, b[22:0]}) << (int'(b[30:23]) - 1);
      if (sa == sb) begin
         m = va + vb; neg = sa;
      end else if (va >= vb) begin
         m = va - vb; neg = sa;
      end else begin
         m = vb - va; neg = sb;
      end
      r = 32'd0;
      x = 1'b0;
      if (m != '0) begin
         p = 0;
         for (int i = 0; i < 300; i++) if (m[i]) p = i;
         e = p - 22;
         if (e >= 255) begin
            r = {neg, 8'hFF, 23'd0}; x = 1'b1;
         end else if (e <= 0) begin
            r = {neg, 31'd0}; x = 1'b1;
         end else begin
            tmp  = m >> (p - 23);
            mask = (300'd1 << (p - 23)) - 300'd1;
            r    = {neg, 8'(e), tmp[22:0]};
            x    = |(m & mask);
         end
      end
   endfunction

   task automatic wait_resp(output int lat);
      lat = 1;
      rdy_leak = 1'b0;
      while (!resp_valid && lat < 200) begin
         if (req_ready || !busy) rdy_leak = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      if (!resp_valid) begin
         nvec++; nfail++;
         $display("FAIL resp_timeout: resp_valid still low after %0d cycles, required high", lat);
      end
   endtask

   task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic x, output int lat);
      int n;
      @(negedge clk);
      req_in1 = a; req_in2 = b; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_in1 = $urandom;
      req_in2 = $urandom;
      wait_resp(lat);
      r = resp_out;
      x = resp_inexact;
   endtask

   initial begin
      logic [31:0] r, er, a, b, rnd;
      logic        x, ex, seen;
      logic [7:0]  ea, eb;
      int          lat, t;

      add_vec(32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 4);
      add_vec(32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 4);
      add_vec(32'hBF800000, 32'hBF800000, 32'h00000000, 1'b0, 4);
      add_vec(32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 1'b0, 28);
      add_vec(32'h3F800000, 32'h30800000, 32'h3F7FFFFF, 1'b1, 5);
      add_vec(32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1);
      add_vec(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1);
      add_vec(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 4);
      add_vec(32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0, 1);
      add_vec(32'h3F800000, 32'hFF800000, 32'h7F800000, 1'b0, 1);
      add_vec(32'h7F800000, 32'hFF800000, 32'h7F800000, 1'b0, 1);
      add_vec(32'h00000000, 32'h40000000, 32'hC0000000, 1'b0, 1);
      add_vec(32'h40000000, 32'h80000000, 32'h40000000, 1'b0, 1);
      add_vec(32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1);
      add_vec(32'h00800000, 32'h00800001, 32'h80000000, 1'b1, 4);
      add_vec(32'h3FC00000, 32'hBFC00000, 32'h40400000, 1'b0, 5);
      add_vec(32'h3F800000, 32'h40000000, 32'hBF800000, 1'b0, 5);

      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_resp_out", resp_out, 32'd0);
      chk("rst_inexact", 32'(resp_inexact), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         do_op(tbl[i].a, tbl[i].b, r, x, lat);
         chk($sformatf("vec%0d_out", i), r, tbl[i].r);
         chk($sformatf("vec%0d_inexact", i), 32'(x), 32'(tbl[i].x));
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
         chk($sformatf("vec%0d_ready_while_busy", i), 32'(rdy_leak), 32'd0);
      end

      // Backpressure: result held for 5 cycles, then back-to-back request.
      repeat (3) @(negedge clk);
      resp_ready = 1'b0;
      do_op(32'h40400000, 32'h3F800000, r, x, lat);
      chk("bp_first_out", r, 32'h40000000);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk($sformatf("bp%0d_valid", k), 32'(resp_valid), 32'd1);
         chk($sformatf("bp%0d_out", k), resp_out, 32'h40000000);
         chk($sformatf("bp%0d_inexact", k), 32'(resp_inexact), 32'd0);
         chk($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      resp_ready = 1'b1;
      req_in1 = 32'hC0A00000;
      req_in2 = 32'h40400000;
      req_valid = 1'b1;
      @(posedge clk); #1;
      chk("b2b_idle_ready", 32'(req_ready), 32'd1);
      chk("b2b_idle_valid", 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("b2b_accepted_busy", 32'(busy), 32'd1);
      wait_resp(lat);
      chk("b2b_out", resp_out, 32'hC1000000);
      chk("b2b_inexact", 32'(resp_inexact), 32'd0);

      // Reset in the middle of a long alignment.
      repeat (3) @(negedge clk);
      req_in1 = 32'h3F800000;
      req_in2 = 32'h33800000;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_req_ready", 32'(req_ready), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      chk("midrst_resp_out", resp_out, 32'd0);
      chk("midrst_inexact", 32'(resp_inexact), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (resp_valid) seen = 1'b1;
      end
      chk("midrst_no_resp", 32'(seen), 32'd0);
      do_op(32'h40400000, 32'h3F800000, r, x, lat);
      chk("after_rst_out", r, 32'h40000000);
      chk("after_rst_inexact", 32'(x), 32'd0);

      // Random normal operands against the exact model.
      for (int i = 0; i < 300; i++) begin
         ea  = 8'($urandom_range(254, 1));
         rnd = $urandom;
         case ($urandom_range(3, 0))
            0: eb = 8'($urandom_range(254, 1));
            1: eb = ea;
            default: begin
               t = int'(ea) + int'($urandom_range(60, 0)) - 30;
               if (t < 1) t = 1;
               if (t > 254) t = 254;
               eb = 8'(t);
            end
         endcase
         a = {rnd[31], ea, 23'($urandom)};
         if (eb == ea && rnd[0])
            b = {rnd[30], eb, a[22:0] ^ {16'd0, rnd[7:1]}};
         else
            b = {rnd[30], eb, 23'($urandom)};
         model(a, b, er, ex);
         do_op(a, b, r, x, lat);
         chk($sformatf("rnd%0d_out(%h-%h)", i, a, b), r, er);
         chk($sformatf("rnd%0d_inexact(%h-%h)", i, a, b), 32'(x), 32'(ex));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
